tpic_chain_monitor: RTL and testbench
=====================================

Name: tpic_chain_monitor

Overview:
- Downstream of the memory-to-TPIC serializer; observes the relay-driver daisy chain during each autonomous refresh frame.
- The TPIC chain is a WIDTH-bit shift register, so the bits returned on tpic_miso in frame N must equal the bits shifted out on tpic_mosi in frame N-1.
- The block checks this bit by bit, reports chain faults (open chain, stuck SO, wrong driver count) and frame-length errors, and keeps saturating statistics readable by the SLU/diag logic.

Parameters:
- WIDTH, 432, bits per refresh frame (54 TPIC drivers x 8).
- CNT_W, 16, width of the saturating error and frame counters.
- IDX_W, 9, width of the bit-index fields; must satisfy 2^IDX_W > WIDTH.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high.
- byps  in  1  diag_byps; high means the uC owns the chain, so the monitor idles.
- sclk  in  1  serializer shift clock (6.25 MHz, rising edge shifts).
- rck  in  1  serializer latch strobe (rising edge marks end of frame).
- sout  in  1  serializer data to the chain (tpic_mosi).
- miso  in  1  chain return (tpic_miso).
- clear  in  1  one-cycle pulse that clears sticky flags and counters.
- frame_done  out  1  one-cycle pulse after each evaluated frame.
- chain_ok  out  1  last evaluated frame matched.
- chain_fault  out  1  sticky; set on any data mismatch.
- len_err  out  1  sticky; set when a frame bit count is not equal to WIDTH.
- first_err_idx  out  IDX_W  bit index of the first mismatch in the most recent faulty frame (0 = first bit shifted).
- err_count  out  CNT_W  count of faulty frames, saturating at all-ones.
- frame_count  out  CNT_W  count of evaluated frames, saturating at all-ones.

Behaviour:
- Reset: all outputs 0. Internal prev_tx is cleared, bit_cnt is 0, hist_valid is 0, state is IDLE.
- Input conditioning:
  - sclk, rck, sout and miso each pass through identical 2-FF synchronizers.
  - Rising edges of the synchronized sclk and rck are detected with one additional register.
  - At a detected sclk edge, the synchronized sout and miso values from the same cycle are used.
  - Latency from an input edge to its internal event is 3 clk cycles.
- State machine states: IDLE, SHIFT, EVAL.
- IDLE:
  - If byps=1, stay in IDLE and force hist_valid=0.
  - On an sclk edge with byps=0: go to SHIFT, set bit_cnt=1, and process bit 0.
- SHIFT, per sclk edge at index k = bit_cnt:
  - Shift sout into cur_tx (MSB-first; bit k lands at cur_tx[WIDTH-1-k]).
  - If hist_valid and k<WIDTH and miso != prev_tx[WIDTH-1-k]: set the frame mismatch flag. If this is the first mismatch of the frame, latch k into err_idx_tmp.
  - bit_cnt increments and saturates at WIDTH+1; any value above WIDTH counts as overflow.
- rck edge in SHIFT: go to EVAL.
- rck edge in IDLE: no action.
- byps rising while in SHIFT: abort to IDLE, discard the frame, hist_valid=0, no frame_done.
- EVAL (exactly 1 cycle), then IDLE:
  - Pulse frame_done=1 and increment frame_count (saturating).
  - If bit_cnt != WIDTH:
    - len_err=1, chain_ok=0, hist_valid=0.
    - The mismatch result of this frame is ignored.
  - Else if hist_valid and mismatch:
    - chain_fault=1, chain_ok=0.
    - first_err_idx=err_idx_tmp, err_count increments (saturating).
  - Else if hist_valid: chain_ok=1.
  - Else (first frame, no history yet): chain_ok is unchanged.
  - When bit_cnt=WIDTH: prev_tx<=cur_tx and hist_valid<=1.
- Simultaneous events:
  - clear coinciding with EVAL: the EVAL update wins for the bits it sets; counters that EVAL does not touch are cleared.
  - clear never alters prev_tx or hist_valid.
  - sclk and rck edges detected in the same cycle: the sclk bit is processed first, then the block enters EVAL.
- Reset mid-frame returns to the reset state immediately; the next frame is treated as the first frame (no compare).

Test Plan:
- WIDTH=16, healthy chain model (miso = sout delayed 16 bits). Send frames 0xA5C3 then 0x0F0F -> frame 1: frame_done with chain_ok=0, err_count=0. Frame 2: chain_ok=1, chain_fault=0, frame_count=2.
- Same setup, flip the returned bit at index 5 in frame 2 -> chain_fault=1, first_err_idx=5, err_count=1, chain_ok=0. Frame 3 healthy -> chain_ok=1, chain_fault still 1.
- miso stuck at 0, frames 0xFFFF, 0xFFFF -> frame 2: first_err_idx=0, err_count=1. Pulse clear -> chain_fault=0, err_count=0, frame_count=0.
- Frame of 15 sclk edges followed by rck -> len_err=1, no compare performed. The next two 16-bit frames behave like frames 1 and 2 of the first test (no compare, then chain_ok=1).
- byps raised after 8 bits of a frame -> no frame_done. After byps drops, the next frame does no compare (hist_valid=0).
- Force err_count to 0xFFFF via 65535 faulty frames (or a bench with CNT_W=4, 16 faults) -> err_count holds at all-ones.

Source files
------------

// File: rtl/tpic_chain_monitor.sv
// TPIC daisy-chain monitor: compares each frame's returned bits against
// the bits shifted out in the previous frame and keeps fault statistics.
module tpic_chain_monitor #(
    parameter int WIDTH = 432,
    parameter int CNT_W = 16,
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byps,
    input  logic             sclk,
    input  logic             rck,
    input  logic             sout,
    input  logic             miso,
    input  logic             clear,
    output logic             frame_done,
    output logic             chain_ok,
    output logic             chain_fault,
    output logic             len_err,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] frame_count
);

    localparam int BC_W = IDX_W + 1;
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);
    localparam logic [BC_W-1:0] BC_OVF  = BC_W'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, EVAL} state_t;

    state_t           state;
    logic [1:0]       sclk_s, rck_s, sout_s, miso_s;
    logic             sclk_d, rck_d;
    logic [WIDTH-1:0] prev_tx, cur_tx, cmp_sr;
    logic [BC_W-1:0]  bit_cnt;
    logic [IDX_W-1:0] err_idx_tmp;
    logic             hist_valid, mism;

    logic sclk_edge, rck_edge, sout_b, miso_b;
    logic miss_first, miss_next;

    assign sclk_edge = sclk_s[1] & ~sclk_d;
    assign rck_edge  = rck_s[1] & ~rck_d;
    assign sout_b    = sout_s[1];
    assign miso_b    = miso_s[1];

    // cmp_sr walks prev_tx MSB-first so no variable bit index is needed
    assign miss_first = hist_valid & (miso_b != prev_tx[WIDTH-1]);
    assign miss_next  = hist_valid & (bit_cnt < BC_FULL)
                      & (miso_b != cmp_sr[WIDTH-1]);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s <= '0;
            rck_s  <= '0;
            sout_s <= '0;
            miso_s <= '0;
            sclk_d <= 1'b0;
            rck_d  <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], sclk};
            rck_s  <= {rck_s[0], rck};
            sout_s <= {sout_s[0], sout};
            miso_s <= {miso_s[0], miso};
            sclk_d <= sclk_s[1];
            rck_d  <= rck_s[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            prev_tx       <= '0;
            cur_tx        <= '0;
            cmp_sr        <= '0;
            bit_cnt       <= '0;
            err_idx_tmp   <= '0;
            hist_valid    <= 1'b0;
            mism          <= 1'b0;
            frame_done    <= 1'b0;
            chain_ok      <= 1'b0;
            chain_fault   <= 1'b0;
            len_err       <= 1'b0;
            first_err_idx <= '0;
            err_count     <= '0;
            frame_count   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (clear) begin
                chain_fault <= 1'b0;
                len_err     <= 1'b0;
                err_count   <= '0;
                frame_count <= '0;
            end
            case (state)
                IDLE: begin
                    if (byps) begin
                        hist_valid <= 1'b0;
                    end else if (sclk_edge) begin
                        state       <= rck_edge ? EVAL : SHIFT;
                        bit_cnt     <= BC_W'(1);
                        cur_tx      <= {cur_tx[WIDTH-2:0], sout_b};
                        cmp_sr      <= prev_tx << 1;
                        mism        <= miss_first;
                        err_idx_tmp <= '0;
                    end
                end
                SHIFT: begin
                    if (byps) begin
                        state      <= IDLE;
                        hist_valid <= 1'b0;
                    end else begin
                        if (sclk_edge) begin
                            cur_tx <= {cur_tx[WIDTH-2:0], sout_b};
                            cmp_sr <= cmp_sr << 1;
                            if (bit_cnt != BC_OVF)
                                bit_cnt <= bit_cnt + 1'b1;
                            if (miss_next) begin
                                mism <= 1'b1;
                                if (!mism)
                                    err_idx_tmp <= bit_cnt[IDX_W-1:0];
                            end
                        end
                        if (rck_edge)
                            state <= EVAL;
                    end
                end
                EVAL: begin
                    state       <= IDLE;
                    frame_done  <= 1'b1;
                    frame_count <= sat_inc(frame_count);
                    if (bit_cnt != BC_FULL) begin
                        len_err    <= 1'b1;
                        chain_ok   <= 1'b0;
                        hist_valid <= 1'b0;
                    end else begin
                        prev_tx    <= cur_tx;
                        hist_valid <= 1'b1;
                        if (hist_valid && mism) begin
                            chain_fault   <= 1'b1;
                            chain_ok      <= 1'b0;
                            first_err_idx <= err_idx_tmp;
                            err_count     <= sat_inc(err_count);
                        end else if (hist_valid) begin
                            chain_ok <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpic_chain_monitor.sv
// Directed plus randomized frames against a frame-level reference model
// of the chain monitor (16-bit chain, 4-bit counters).
module tb_tpic_chain_monitor;

    localparam int W  = 16;
    localparam int CW = 4;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          byps = 1'b0;
    logic          sclk = 1'b0;
    logic          rck = 1'b0;
    logic          sout = 1'b0;
    logic          miso = 1'b0;
    logic          clear = 1'b0;
    logic          frame_done;
    logic          chain_ok;
    logic          chain_fault;
    logic          len_err;
    logic [IW-1:0] first_err_idx;
    logic [CW-1:0] err_count;
    logic [CW-1:0] frame_count;

    tpic_chain_monitor #(.WIDTH(W), .CNT_W(CW), .IDX_W(IW)) dut (
        .clk(clk),
        .reset(reset),
        .byps(byps),
        .sclk(sclk),
        .rck(rck),
        .sout(sout),
        .miso(miso),
        .clear(clear),
        .frame_done(frame_done),
        .chain_ok(chain_ok),
        .chain_fault(chain_fault),
        .len_err(len_err),
        .first_err_idx(first_err_idx),
        .err_count(err_count),
        .frame_count(frame_count)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;

    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    // reference model state
    logic [W-1:0]  m_prev = '0;
    logic          m_hv = 1'b0;
    logic          m_ok = 1'b0;
    logic          m_fault = 1'b0;
    logic          m_len = 1'b0;
    logic [IW-1:0] m_idx = '0;
    logic [CW-1:0] m_errc = '0;
    logic [CW-1:0] m_frc = '0;

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ok"}, 32'(chain_ok), 32'(m_ok));
        chk({tag, ".fault"}, 32'(chain_fault), 32'(m_fault));
        chk({tag, ".len"}, 32'(len_err), 32'(m_len));
        chk({tag, ".idx"}, 32'(first_err_idx), 32'(m_idx));
        chk({tag, ".errc"}, 32'(err_count), 32'(m_errc));
        chk({tag, ".frc"}, 32'(frame_count), 32'(m_frc));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [W-1:0] tx,
                             input logic [W-1:0] rx, input int n);
        for (int k = 0; k < n; k++) begin
            sout = tx[W-1-k];
            miso = rx[W-1-k];
            cyc(2);
            sclk = 1'b1;
            cyc(4);
            sclk = 1'b0;
            cyc(3);
        end
    endtask

    // one complete frame; model evaluated from whole-frame bit vectors
    task automatic do_frame(input string tag, input logic [W-1:0] tx,
                            input logic [W-1:0] rx, input int n);
        bit seen = 0;
        int first = -1;
        send_bits(tx, rx, n);
        rck = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        chk({tag, ".done"}, 32'(seen), 32'd1);
        rck = 1'b0;
        m_frc = sat(m_frc);
        if (n != W) begin
            m_len = 1'b1;
            m_ok = 1'b0;
            m_hv = 1'b0;
        end else begin
            if (m_hv) begin
                for (int k = W - 1; k >= 0; k--)
                    if (rx[W-1-k] != m_prev[W-1-k]) first = k;
                if (first >= 0) begin
                    m_fault = 1'b1;
                    m_ok = 1'b0;
                    m_idx = IW'(first);
                    m_errc = sat(m_errc);
                end else begin
                    m_ok = 1'b1;
                end
            end
            m_prev = tx;
            m_hv = 1'b1;
        end
        check_all(tag);
        cyc(4);
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_hv = 1'b0;
        m_ok = 1'b0;
        m_fault = 1'b0;
        m_len = 1'b0;
        m_idx = '0;
        m_errc = '0;
        m_frc = '0;
    endtask

    initial begin
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        int n;
        int fd0;

        cyc(4);
        chk("rst.fd", 32'(frame_done), 32'd0);
        check_all("rst");
        reset = 1'b0;
        cyc(4);

        // healthy chain: first frame has no history
        do_frame("h1", 16'hA5C3, 16'h0000, W);
        do_frame("h2", 16'h0F0F, m_prev, W);

        // single flipped return bit at index 5
        do_frame("flip", 16'h3C96, m_prev ^ 16'h0400, W);
        do_frame("heal", 16'h1234, m_prev, W);

        // stuck-low SO then clear
        do_frame("stk1", 16'hFFFF, 16'h0000, W);
        do_frame("stk2", 16'hFFFF, 16'h0000, W);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        m_fault = 1'b0;
        m_len = 1'b0;
        m_errc = '0;
        m_frc = '0;
        cyc(2);
        check_all("clr");

        // short frame breaks history
        do_frame("short", 16'hBEEF, m_prev, 15);
        do_frame("s_a", 16'h5555, 16'hAAAA, W);
        do_frame("s_b", 16'h6789, m_prev, W);

        // bypass mid-frame aborts without frame_done
        fd0 = fd_cnt;
        send_bits(16'hC0DE, m_prev, 8);
        byps = 1'b1;
        cyc(20);
        chk("byps.nodone", 32'(fd_cnt), 32'(fd0));
        byps = 1'b0;
        m_hv = 1'b0;
        cyc(4);
        do_frame("byp_a", 16'h9A9A, 16'hFFFF, W);
        do_frame("byp_b", 16'h4B4B, m_prev, W);

        // err_count saturation with every frame faulty
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        m_fault = 1'b0;
        m_len = 1'b0;
        m_errc = '0;
        m_frc = '0;
        for (int i = 0; i < 17; i++) begin
            tx = W'($urandom);
            do_frame("sat", tx, ~m_prev, W);
        end
        chk("sat.errc", 32'(err_count), 32'hF);

        // randomized frames with occasional faults and short lengths
        for (int i = 0; i < 24; i++) begin
            tx = W'($urandom);
            rx = m_prev;
            if ($urandom_range(0, 2) == 0)
                rx[$urandom_range(0, W - 1)] ^= 1'b1;
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : W;
            if ($urandom_range(0, 9) == 0) begin
                clear = 1'b1;
                cyc(1);
                clear = 1'b0;
                m_fault = 1'b0;
                m_len = 1'b0;
                m_errc = '0;
                m_frc = '0;
            end
            do_frame("rnd", tx, rx, n);
        end

        // reset in the middle of a frame
        send_bits(16'hF00D, m_prev, 5);
        reset = 1'b1;
        cyc(2);
        model_reset();
        check_all("mrst");
        reset = 1'b0;
        cyc(4);
        do_frame("mr_a", 16'h7E57, 16'h1111, W);
        do_frame("mr_b", 16'h0BAD, m_prev, W);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
